traffic_ctrl_multi: RTL

Parametrised traffic-light sequencer for NUM_DIR approaches. Each approach gets Green, then Yellow, then all-Red clearance, and the sequence rotates through the approaches in order. Runs entirely in the clk_i domain, advancing on a one-cycle tick_i enable. Phase lengths are adjustable at runtime by switches and buttons, and a latched pedestrian request shortens the current green. It sits between the board switch/button inputs and the LED/7-segment drivers.

---
 rtl/traffic_pkg.sv | 10 +
 rtl/traffic_ctrl_multi_btn_lockout.sv | 19 +
 rtl/traffic_ctrl_multi.sv | 114 +++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared colour, mode and phase encodings for the traffic sequencer.
package traffic_pkg;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] YELLOW = 3'b110;
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] WHITE  = 3'b111;
    localparam logic [2:0] OFF    = 3'b000;
    typedef enum logic [1:0] {NORMAL = 2'd0, ADJ_G = 2'd1, ADJ_Y = 2'd2, ADJ_R = 2'd3} mode_e;
    typedef enum logic [1:0] {G = 2'd0, Y = 2'd1, R = 2'd2} phase_e;
endpackage

// File: rtl/traffic_ctrl_multi_btn_lockout.sv
// btn_lockout: passes the first press as a one-cycle pulse, then ignores the
// button for DB_CYCLES clocks.
module btn_lockout #(
    parameter int DB_CYCLES = 33554431
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    logic [CW-1:0] lock;
    assign press = btn && lock == '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lock <= '0;
        else if (press) lock <= CW'(DB_CYCLES);
        else if (lock != '0) lock <= lock - 1'b1;
    end
endmodule

// File: rtl/traffic_ctrl_multi.sv
// traffic_ctrl_multi: rotating G/Y/all-red sequencer for NUM_DIR approaches
// with runtime-adjustable phase lengths and a pedestrian green cut.
module traffic_ctrl_multi
    import traffic_pkg::*;
#(
    parameter int NUM_DIR   = 2,
    parameter int TIME_W    = 4,
    parameter int DEF_G     = 5,
    parameter int DEF_Y     = 2,
    parameter int DEF_R     = 1,
    parameter int MIN_LEN   = 1,
    parameter int MAX_LEN   = 15,
    parameter int PED_CUT   = 2,
    parameter int DB_CYCLES = 33554431
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       tick_i,
    input  logic [1:0]                 mode_i,
    input  logic [2:0]                 btn_i,
    input  logic                       ped_req_i,
    output logic [3*NUM_DIR-1:0]       light_o,
    output logic [TIME_W-1:0]          count_o,
    output logic [$clog2(NUM_DIR)-1:0] dir_o,
    output logic                       ped_pend_o
);
    localparam int DW = $clog2(NUM_DIR);
    typedef logic [TIME_W-1:0] len_t;
    localparam len_t LG   = len_t'(DEF_G);
    localparam len_t LY   = len_t'(DEF_Y);
    localparam len_t LR   = len_t'(DEF_R);
    localparam len_t LMIN = len_t'(MIN_LEN);
    localparam len_t LMAX = len_t'(MAX_LEN);
    localparam len_t LCUT = len_t'(PED_CUT);
    localparam len_t ONE  = len_t'(1);

    if (DEF_G < MIN_LEN || DEF_G > MAX_LEN || DEF_Y < MIN_LEN || DEF_Y > MAX_LEN ||
        DEF_R < MIN_LEN || DEF_R > MAX_LEN || PED_CUT < MIN_LEN || PED_CUT > MAX_LEN ||
        MAX_LEN > 2**TIME_W - 1 || NUM_DIR < 2 || NUM_DIR > 8) begin : g_bad_param
        $error("traffic_ctrl_multi: parameter out of range");
    end

    mode_e          mode;
    phase_e         phase, phase_n;
    logic [DW-1:0]  dir, dir_n;
    len_t           cnt, cnt_n, glen, ylen, rlen, sel_len, sel_def, len_n, load_len;
    logic           ped_pend, ped_n, norm, adv, cut;
    logic [2:0]     press;

    assign mode       = mode_e'(mode_i);
    assign dir_o      = dir;
    assign ped_pend_o = ped_pend;

    for (genvar i = 0; i < 3; i++) begin : g_btn
        btn_lockout #(.DB_CYCLES(DB_CYCLES)) u_lock (
            .clk(clk_i), .rst(rst_i), .btn(btn_i[i]), .press(press[i])
        );
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase <= G;
            dir   <= '0;
        end else begin
            phase <= phase_n;
            dir   <= dir_n;
        end
    end

    always_comb begin
        norm     = mode == NORMAL;
        adv      = norm && tick_i && cnt <= ONE;
        cut      = norm && phase == G && cnt > LCUT && (ped_req_i || ped_pend);
        phase_n  = adv ? (phase == G ? Y : phase == Y ? R : G) : phase;
        dir_n    = (adv && phase == R) ? (dir == DW'(NUM_DIR - 1) ? '0 : dir + 1'b1) : dir;
        load_len = phase_n == G ? glen : phase_n == Y ? ylen : rlen;
        // a cut needs cnt > PED_CUT >= 1, so it never collides with a phase advance
        cnt_n    = !norm ? cnt : cut ? LCUT : adv ? load_len : tick_i ? cnt - ONE : cnt;
        ped_n    = (adv && phase == G) ? 1'b0 : ped_pend | ped_req_i;
        sel_len  = mode == ADJ_G ? glen : mode == ADJ_Y ? ylen : rlen;
        sel_def  = mode == ADJ_G ? LG : mode == ADJ_Y ? LY : LR;
        len_n    = press[0] ? sel_def :
                   press[1] ? (sel_len >= LMAX ? LMAX : sel_len + ONE) :
                   press[2] ? (sel_len <= LMIN ? LMIN : sel_len - ONE) : sel_len;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt      <= LG;
            ped_pend <= 1'b0;
            glen     <= LG;
            ylen     <= LY;
            rlen     <= LR;
            count_o  <= LG;
        end else begin
            cnt      <= cnt_n;
            ped_pend <= ped_n;
            if (mode == ADJ_G) glen <= len_n;
            if (mode == ADJ_Y) ylen <= len_n;
            if (mode == ADJ_R) rlen <= len_n;
            count_o  <= norm ? cnt : sel_len;
        end
    end

    always_comb begin
        light_o = '0;
        for (int d = 0; d < NUM_DIR; d++)
            light_o[3*d +: 3] = mode == ADJ_R ? WHITE :
                                mode == ADJ_Y ? YELLOW :
                                mode == ADJ_G ? (d == 0 ? GREEN : RED) :
                                (DW'(d) != dir || phase == R) ? RED :
                                phase == G ? GREEN : YELLOW;
    end
endmodule
